// File: rtl/timer_cmd_pkg.sv
// Shared types and constants for the interval-timer command master:
// op codes, timer register map, control bits and the sequencer states.
package timer_cmd_pkg;

    typedef enum logic [2:0] {
        OP_CONFIG   = 3'd0,
        OP_STOP     = 3'd1,
        OP_SNAPSHOT = 3'd2,
        OP_STATUS   = 3'd3,
        OP_ACK      = 3'd4,
        OP_CLRCNT   = 3'd5
    } op_e;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        S_IDLE, S_WR1, S_WR2, S_WR3, S_WR4, S_RD_ISSUE, S_RD_LO, S_RD_HI, S_RESP
    } state_e;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } av_bus_t;

    localparam av_bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, wdata: 16'd0};

    function automatic logic [15:0] ctrl_word(input logic start, input logic stop,
                                              input logic cont, input logic ito);
        logic [15:0] w;
        w             = '0;
        w[CTRL_ITO]   = ito;
        w[CTRL_CONT]  = cont;
        w[CTRL_START] = start;
        w[CTRL_STOP]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/timer_cmd_master_if.sv
// Avalon-MM link between the command master and the interval timer slave port.
interface timer_cmd_master_if;
    logic        chipselect;
    logic        write_n;
    logic [2:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (output chipselect, write_n, address, writedata, input readdata);
    modport slave  (input chipselect, write_n, address, writedata, output readdata);
endinterface

// File: rtl/irq_edge_counter.sv
// Counts rising edges of the timer interrupt, saturating at all-ones.
// A clear that lands on an edge leaves the count at one.
module irq_edge_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         irq,
    input  logic         clr,
    output logic [W-1:0] count
);
    logic irq_q;
    logic rise;

    assign rise = irq & ~irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
            count <= '0;
        end else begin
            irq_q <= irq;
            if (clr)
                count <= rise ? W'(1) : '0;
            else if (rise && (count != '1))
                count <= count + W'(1);
        end
    end
endmodule

// File: rtl/timer_cmd_master.sv
// Command-port front end for the interval timer: each accepted command becomes a
// fixed back-to-back Avalon sequence followed by a single response pulse.
module timer_cmd_master
    import timer_cmd_pkg::*;
#(
    parameter int IRQ_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [31:0]           cmd_period,
    input  logic                  cmd_cont,
    input  logic                  cmd_ien,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    timer_cmd_master_if.master    av,
    input  logic                  timer_irq,
    output logic [IRQ_CNT_W-1:0]  irq_count
);
    state_e      state_q, state_d;
    av_bus_t     bus_q, bus_d;
    logic [2:0]  op_q, cur_op;
    logic [31:0] period_q;
    logic        cont_q, ien_q, cont_sh, ien_sh;
    logic [15:0] lo_q;
    logic        accept, rsp_load, err_d;
    logic [31:0] data_d;

    assign cmd_ready = reset_n && (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    // The first bus cycle is chosen on the acceptance edge, before op_q is loaded.
    assign cur_op    = (state_q == S_IDLE) ? cmd_op : op_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) begin
                case (cmd_op)
                    OP_CONFIG, OP_STOP, OP_SNAPSHOT, OP_ACK: state_d = S_WR1;
                    OP_STATUS:                               state_d = S_RD_ISSUE;
                    default:                                 state_d = S_RESP;
                endcase
            end
            S_WR1: begin
                case (op_q)
                    OP_CONFIG:   state_d = S_WR2;
                    OP_SNAPSHOT: state_d = S_RD_ISSUE;
                    default:     state_d = S_RESP;
                endcase
            end
            S_WR2:      state_d = S_WR3;
            S_WR3:      state_d = S_WR4;
            S_WR4:      state_d = S_RESP;
            S_RD_ISSUE: state_d = (op_q == OP_SNAPSHOT) ? S_RD_LO : S_RD_HI;
            S_RD_LO:    state_d = S_RD_HI;
            S_RD_HI:    state_d = S_RESP;
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Bus word for the cycle we are about to enter, so the outputs can be registered.
    always_comb begin
        bus_d = BUS_IDLE;
        case (state_d)
            S_WR1: begin
                bus_d.cs      = 1'b1;
                bus_d.write_n = 1'b0;
                case (cur_op)
                    OP_CONFIG: begin
                        bus_d.addr  = ADDR_CONTROL;
                        bus_d.wdata = ctrl_word(1'b0, 1'b1, 1'b0, 1'b0);
                    end
                    OP_STOP: begin
                        bus_d.addr  = ADDR_CONTROL;
                        bus_d.wdata = ctrl_word(1'b0, 1'b1, cont_sh, ien_sh);
                    end
                    OP_SNAPSHOT: bus_d.addr = ADDR_SNAPL;
                    default:     bus_d.addr = ADDR_STATUS;
                endcase
            end
            S_WR2: begin
                bus_d.cs      = 1'b1;
                bus_d.write_n = 1'b0;
                bus_d.addr    = ADDR_PERIODL;
                bus_d.wdata   = period_q[15:0];
            end
            S_WR3: begin
                bus_d.cs      = 1'b1;
                bus_d.write_n = 1'b0;
                bus_d.addr    = ADDR_PERIODH;
                bus_d.wdata   = period_q[31:16];
            end
            S_WR4: begin
                bus_d.cs      = 1'b1;
                bus_d.write_n = 1'b0;
                bus_d.addr    = ADDR_CONTROL;
                bus_d.wdata   = ctrl_word(1'b1, 1'b0, cont_q, ien_q);
            end
            S_RD_ISSUE: begin
                bus_d.cs   = 1'b1;
                bus_d.addr = (cur_op == OP_SNAPSHOT) ? ADDR_SNAPL : ADDR_STATUS;
            end
            S_RD_LO: begin
                bus_d.cs   = 1'b1;
                bus_d.addr = ADDR_SNAPH;
            end
            default: bus_d = BUS_IDLE;
        endcase
    end

    always_comb begin
        rsp_load = (state_d == S_RESP);
        err_d    = (state_q == S_IDLE) && (cmd_op > OP_CLRCNT);
        data_d   = '0;
        if (state_q == S_RD_HI)
            data_d = (op_q == OP_SNAPSHOT) ? {av.readdata, lo_q} : {30'b0, av.readdata[1:0]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            bus_q     <= BUS_IDLE;
            op_q      <= '0;
            period_q  <= '0;
            cont_q    <= 1'b0;
            ien_q     <= 1'b0;
            cont_sh   <= 1'b0;
            ien_sh    <= 1'b0;
            lo_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            rsp_valid <= rsp_load;
            if (rsp_load) begin
                rsp_data <= data_d;
                rsp_err  <= err_d;
            end
            if (accept) begin
                op_q     <= cmd_op;
                period_q <= cmd_period;
                cont_q   <= cmd_cont;
                ien_q    <= cmd_ien;
            end
            if (state_q == S_WR4) begin
                cont_sh <= cont_q;
                ien_sh  <= ien_q;
            end
            if (state_q == S_RD_LO)
                lo_q <= av.readdata;
        end
    end

    assign av.chipselect = bus_q.cs;
    assign av.write_n    = bus_q.write_n;
    assign av.address    = bus_q.addr;
    assign av.writedata  = bus_q.wdata;

    irq_edge_counter #(.W(IRQ_CNT_W)) u_irq_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .irq     (timer_irq),
        .clr     (accept && (cmd_op == OP_CLRCNT)),
        .count   (irq_count)
    );
endmodule

// File: tb/tb_timer_cmd_master.sv
// Directed bench for timer_cmd_master with a small interval-timer slave model.
module tb_timer_cmd_master;
    import timer_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_period = 32'd0;
    logic        cmd_cont = 1'b0, cmd_ien = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        timer_irq = 1'b0;
    logic [15:0] irq_count;

    // Narrow-counter instance used only for saturation.
    logic        irq_s = 1'b0;
    logic        ready_s, rv_s, err_s;
    logic [31:0] data_s;
    logic [3:0]  irq_count_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    timer_cmd_master_if av ();
    timer_cmd_master_if av_s ();
    assign av_s.readdata = 16'd0;

    timer_cmd_master #(.IRQ_CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_cont(cmd_cont), .cmd_ien(cmd_ien),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .av(av),
        .timer_irq(timer_irq), .irq_count(irq_count)
    );

    timer_cmd_master #(.IRQ_CNT_W(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .cmd_valid(1'b0), .cmd_ready(ready_s),
        .cmd_op(3'd0), .cmd_period(32'd0), .cmd_cont(1'b0), .cmd_ien(1'b0),
        .rsp_valid(rv_s), .rsp_data(data_s), .rsp_err(err_s), .av(av_s),
        .timer_irq(irq_s), .irq_count(irq_count_s)
    );

    // Timer slave model: registered readdata, snapshot latched on a SNAPL write.
    logic        m_run = 1'b0, m_to = 1'b0, set_to = 1'b0;
    logic [31:0] snap = 32'd0, snap_src = 32'd0;
    logic [15:0] rd = 16'd0;
    assign av.readdata = rd;

    always @(posedge clk) begin
        if (set_to) m_to <= 1'b1;
        if (av.chipselect && !av.write_n) begin
            case (av.address)
                3'd0: m_to <= 1'b0;
                3'd1: begin
                    if (av.writedata[2]) m_run <= 1'b1;
                    if (av.writedata[3]) m_run <= 1'b0;
                end
                3'd4: snap <= snap_src;
                default: ;
            endcase
        end
        if (av.chipselect && av.write_n) begin
            case (av.address)
                3'd0:    rd <= {14'd0, m_run, m_to};
                3'd4:    rd <= snap[15:0];
                3'd5:    rd <= snap[31:16];
                default: rd <= 16'd0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    logic        b_cs[1:7], b_wn[1:7];
    logic [2:0]  b_ad[1:7];
    logic [15:0] b_wd[1:7];
    int          rv_at, rv_cnt;
    logic [31:0] r_data, r_late;
    logic        r_err;

    // Drive one command in cycle A, then log bus and response for A+1..A+7.
    task automatic do_cmd(input logic [2:0] op, input logic [31:0] per,
                          input logic c, input logic i, input logic irq_a);
        @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_period = per; cmd_cont = c; cmd_ien = i;
        timer_irq = irq_a;
        rv_at = -1; rv_cnt = 0; r_data = 32'hdead_beef; r_err = 1'bx;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            b_cs[k] = av.chipselect; b_wn[k] = av.write_n;
            b_ad[k] = av.address;    b_wd[k] = av.writedata;
            if (rsp_valid) begin
                rv_cnt++;
                if (rv_at < 0) begin rv_at = k; r_data = rsp_data; r_err = rsp_err; end
            end
        end
        r_late = rsp_data;
    endtask

    function automatic logic [31:0] busw(input logic cs, input logic wn,
                                         input logic [2:0] a, input logic [15:0] d);
        return {11'd0, cs, wn, a, d};
    endfunction

    task automatic chk_bus(input string tag, input int k, input logic cs, input logic wn,
                           input logic [2:0] a, input logic [15:0] d);
        chk(tag, busw(b_cs[k], b_wn[k], b_ad[k], b_wd[k]), busw(cs, wn, a, d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_bus", busw(av.chipselect, av.write_n, av.address, av.writedata), busw(0, 1, 0, 0));
        chk("rst_irq_count", irq_count, 0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);

        // CONFIG
        do_cmd(3'd0, 32'h0001_86A0, 1'b1, 1'b1, 1'b0);
        chk_bus("cfg_w1", 1, 1, 0, 3'd1, 16'h0008);
        chk_bus("cfg_w2", 2, 1, 0, 3'd2, 16'h86A0);
        chk_bus("cfg_w3", 3, 1, 0, 3'd3, 16'h0001);
        chk_bus("cfg_w4", 4, 1, 0, 3'd1, 16'h0007);
        chk_bus("cfg_idle", 5, 0, 1, 3'd0, 16'h0000);
        chk("cfg_rv_at", rv_at, 5);
        chk("cfg_rv_cnt", rv_cnt, 1);
        chk("cfg_err", r_err, 0);

        // SNAPSHOT
        snap_src = 32'h0012_3456;
        do_cmd(3'd2, 32'd0, 1'b0, 1'b0, 1'b0);
        chk_bus("snap_w", 1, 1, 0, 3'd4, 16'h0000);
        chk_bus("snap_r4", 2, 1, 1, 3'd4, 16'h0000);
        chk_bus("snap_r5", 3, 1, 1, 3'd5, 16'h0000);
        chk("snap_rv_at", rv_at, 5);
        chk("snap_data", r_data, 32'h0012_3456);
        chk("snap_hold", r_late, 32'h0012_3456);

        // STATUS after timeout, ACK, STATUS
        @(negedge clk); set_to = 1'b1;
        @(negedge clk); set_to = 1'b0;
        do_cmd(3'd3, 32'd0, 1'b0, 1'b0, 1'b0);
        chk_bus("stat_r0", 1, 1, 1, 3'd0, 16'h0000);
        chk("stat_rv_at", rv_at, 3);
        chk("stat_data_to", r_data, 32'h3);
        do_cmd(3'd4, 32'd0, 1'b0, 1'b0, 1'b0);
        chk_bus("ack_w0", 1, 1, 0, 3'd0, 16'h0000);
        chk("ack_rv_at", rv_at, 2);
        do_cmd(3'd3, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("stat_data_acked", r_data, 32'h2);

        // STOP keeps shadow cont/ien
        do_cmd(3'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        chk_bus("stop_w", 1, 1, 0, 3'd1, 16'h000B);
        chk("stop_rv_at", rv_at, 2);

        // Illegal op
        do_cmd(3'd7, 32'd0, 1'b0, 1'b0, 1'b0);
        chk_bus("ill_nobus", 1, 0, 1, 3'd0, 16'h0000);
        chk("ill_rv_at", rv_at, 1);
        chk("ill_err", r_err, 1);
        chk("ill_data", r_data, 0);

        // IRQ edges, then CLRCNT on a fourth edge
        repeat (3) begin
            @(negedge clk); timer_irq = 1'b1;
            @(negedge clk); timer_irq = 1'b0;
        end
        @(negedge clk);
        chk("irq_cnt3", irq_count, 3);
        do_cmd(3'd5, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("clr_rv_at", rv_at, 1);
        chk("clr_err", r_err, 0);
        chk("clr_on_edge", irq_count, 1);
        timer_irq = 1'b0;

        // Reset in the middle of CONFIG
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_period = 32'h0000_0100; cmd_cont = 1'b1; cmd_ien = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_cfg_w2", busw(av.chipselect, av.write_n, av.address, av.writedata), busw(1, 0, 2, 16'h0100));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_bus", busw(av.chipselect, av.write_n, av.address, av.writedata), busw(0, 1, 0, 0));
        chk("mid_rst_rv", rsp_valid, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        chk("mid_rst_irq", irq_count, 0);
        @(negedge clk); reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || av.chipselect) seen++;
        end
        chk("mid_rst_no_activity", seen, 0);
        chk("mid_rst_ready_after", cmd_ready, 1);
        do_cmd(3'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        chk_bus("post_rst_stop", 1, 1, 0, 3'd1, 16'h0008);

        // Saturation on the 4-bit instance
        repeat (14) begin
            @(negedge clk); irq_s = 1'b1;
            @(negedge clk); irq_s = 1'b0;
        end
        @(negedge clk);
        chk("sat_cnt14", irq_count_s, 14);
        repeat (7) begin
            @(negedge clk); irq_s = 1'b1;
            @(negedge clk); irq_s = 1'b0;
        end
        @(negedge clk);
        chk("sat_cnt_max", irq_count_s, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
